// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared widths and FSM state encoding for the AES stream
// controller. Counter mode is selected with the macro AES_STREAM_CTR_EN.
package aes_stream_pkg;

  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 256;
  localparam int COUNT_W = 32;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_KEY_INIT  = 3'd1;
  localparam logic [2:0] ST_KEY_WAIT  = 3'd2;
  localparam logic [2:0] ST_BLK_ISSUE = 3'd3;
  localparam logic [2:0] ST_BLK_WAIT  = 3'd4;
  localparam logic [2:0] ST_OUT_HOLD  = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    KEY_INIT  = ST_KEY_INIT,
    KEY_WAIT  = ST_KEY_WAIT,
    BLK_ISSUE = ST_BLK_ISSUE,
    BLK_WAIT  = ST_BLK_WAIT,
    OUT_HOLD  = ST_OUT_HOLD
  } state_t;

endpackage

// File: rtl/aes_stream_ctrl_if.sv
// aes_stream_ctrl_if: input (s_*) and output (m_*) block streams.
// Handshake: a block moves on a rising clk edge where valid and ready are
// both high; the source keeps valid and data stable until that edge, and
// the sink may raise or drop ready at any time.
interface aes_stream_ctrl_if;

  logic                              s_valid;
  logic                              s_ready;
  logic [aes_stream_pkg::BLOCK_W-1:0] s_data;
  logic                              m_valid;
  logic                              m_ready;
  logic [aes_stream_pkg::BLOCK_W-1:0] m_data;

  // Controller side: consumes s_*, produces m_*.
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  // Host side: produces s_*, consumes m_*.
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

endinterface

// File: rtl/aes_ctr_inc.sv
// aes_ctr_inc: increments the low CTR_WIDTH bits of a 128-bit counter block
// with wrap-around; the upper bits pass through untouched.
module aes_ctr_inc
  import aes_stream_pkg::*;
#(
  parameter int CTR_WIDTH = 32
) (
  input  logic [BLOCK_W-1:0] ctr_in,
  output logic [BLOCK_W-1:0] ctr_out
);

  // Low field increments modulo 2^CTR_WIDTH, rest copied.
  always_comb begin
    ctr_out                  = ctr_in;
    ctr_out[CTR_WIDTH-1:0]   = ctr_in[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
  end

endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: sequences key expansion and one-block-at-a-time cipher
// operations on an external AES core, with valid/ready streams for blocks.
// Key loads are captured immediately into a pending set and only applied
// when the controller is back in IDLE, so an in-flight block always finishes
// with the key it started with.
// Optional counter mode: define AES_STREAM_CTR_EN.
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int CTR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               key_load,
  input  logic [KEY_W-1:0]   key,
  input  logic               keylen,
  input  logic               encdec,
  input  logic [BLOCK_W-1:0] iv,
  output logic               key_valid,
  aes_stream_ctrl_if.slave   stream,
  output logic [COUNT_W-1:0] blk_count,
  output logic               core_init,
  output logic               core_next,
  output logic               core_encdec,
  output logic [KEY_W-1:0]   core_key,
  output logic               core_keylen,
  output logic [BLOCK_W-1:0] core_block,
  input  logic               core_ready,
  input  logic               core_result_valid,
  input  logic [BLOCK_W-1:0] core_result,
  output state_t             fsm_state
);

  state_t             state;
  state_t             state_nxt;
  logic               key_pend;
  logic [KEY_W-1:0]   pend_key;
  logic [KEY_W-1:0]   act_key;
  logic               pend_keylen;
  logic               act_keylen;
  logic               pend_encdec;
  logic               act_encdec;
  logic [BLOCK_W-1:0] data_r;
  logic [BLOCK_W-1:0] result_w;
  logic               s_ready_w;
  logic               accept;
  logic               blk_done;
  logic               key_service;
  logic               unused_cfg;

  assign key_service    = (state == IDLE) && key_pend;
  assign s_ready_w      = (state == IDLE) && key_valid && !key_pend;
  assign accept         = stream.s_valid && s_ready_w;
  assign blk_done       = (state == BLK_WAIT) && core_ready && core_result_valid;
  assign stream.s_ready = s_ready_w;
  assign fsm_state      = state;
  assign core_key       = act_key;
  assign core_keylen    = act_keylen;

`ifdef AES_STREAM_CTR_EN
  logic [BLOCK_W-1:0] pend_iv;
  logic [BLOCK_W-1:0] ctr_r;
  logic [BLOCK_W-1:0] ctr_nxt;

  aes_ctr_inc #(.CTR_WIDTH(CTR_WIDTH)) u_ctr_inc (
    .ctr_in  (ctr_r),
    .ctr_out (ctr_nxt)
  );

  // The core always encrypts the counter; the keystream is XORed with data.
  assign core_block  = ctr_r;
  assign core_encdec = 1'b1;
  assign result_w    = core_result ^ data_r;
  assign unused_cfg  = act_encdec;

  // Counter: seeded from iv at key service, advanced after each block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_iv <= '0;
      ctr_r   <= '0;
    end else begin
      if (key_load) pend_iv <= iv;
      if (key_service) begin
        ctr_r <= pend_iv;
      end else if (blk_done) begin
        ctr_r <= ctr_nxt;
      end
    end
  end
`else
  // Plain block mode: the core sees the input block directly.
  assign core_block  = data_r;
  assign core_encdec = act_encdec;
  assign result_w    = core_result;
  assign unused_cfg  = (^iv) ^ (CTR_WIDTH == 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and single-cycle core strobes; a pending key beats new data.
  always_comb begin
    state_nxt = state;
    core_init = 1'b0;
    core_next = 1'b0;
    case (state)
      IDLE: begin
        if (key_pend)    state_nxt = KEY_INIT;
        else if (accept) state_nxt = BLK_ISSUE;
      end
      KEY_INIT: begin
        core_init = 1'b1;
        state_nxt = KEY_WAIT;
      end
      KEY_WAIT: begin
        if (core_ready) state_nxt = IDLE;
      end
      BLK_ISSUE: begin
        core_next = 1'b1;
        state_nxt = BLK_WAIT;
      end
      BLK_WAIT: begin
        if (core_ready && core_result_valid) state_nxt = OUT_HOLD;
      end
      OUT_HOLD: begin
        if (stream.m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Key capture: pending set follows key_load, active set is taken in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_pend    <= 1'b0;
      key_valid   <= 1'b0;
      pend_key    <= '0;
      pend_keylen <= 1'b0;
      pend_encdec <= 1'b0;
      act_key     <= '0;
      act_keylen  <= 1'b0;
      act_encdec  <= 1'b0;
    end else begin
      if (key_service) begin
        key_pend   <= 1'b0;
        key_valid  <= 1'b0;
        act_key    <= pend_key;
        act_keylen <= pend_keylen;
        act_encdec <= pend_encdec;
      end else if ((state == KEY_WAIT) && core_ready) begin
        key_valid <= 1'b1;
      end
      // A load in the same cycle as service stays pending for the next pass.
      if (key_load) begin
        key_pend    <= 1'b1;
        pend_key    <= key;
        pend_keylen <= keylen;
        pend_encdec <= encdec;
      end
    end
  end

  // Block datapath: input latch, output register and delivered-block count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r         <= '0;
      stream.m_valid <= 1'b0;
      stream.m_data  <= '0;
      blk_count      <= '0;
    end else begin
      if (accept && !key_pend) data_r <= stream.s_data;
      if (key_service) begin
        blk_count <= '0;
      end else if (blk_done) begin
        blk_count <= blk_count + COUNT_W'(1);
      end
      if (blk_done) begin
        stream.m_valid <= 1'b1;
        stream.m_data  <= result_w;
      end else if ((state == OUT_HOLD) && stream.m_ready) begin
        stream.m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: drives the controller against a behavioural cipher
// core stand-in; expected outputs come from a key/counter reference model.
// Build with AES_STREAM_CTR_EN defined to exercise counter mode.
module tb_aes_stream_ctrl;
  import aes_stream_pkg::*;

  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_load = 1'b0;
  logic [255:0] key = '0;
  logic         keylen = 1'b0;
  logic         encdec = 1'b0;
  logic [127:0] iv = '0;
  logic         key_valid;
  logic [31:0]  blk_count;
  logic         core_init, core_next, core_encdec, core_keylen;
  logic [255:0] core_key;
  logic [127:0] core_block;
  logic         core_ready, core_result_valid;
  logic [127:0] core_result;
  state_t       fsm_state;

  aes_stream_ctrl_if sif();

  aes_stream_ctrl #(.CTR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .key_load(key_load), .key(key),
    .keylen(keylen), .encdec(encdec), .iv(iv), .key_valid(key_valid),
    .stream(sif), .blk_count(blk_count), .core_init(core_init),
    .core_next(core_next), .core_encdec(core_encdec), .core_key(core_key),
    .core_keylen(core_keylen), .core_block(core_block), .core_ready(core_ready),
    .core_result_valid(core_result_valid), .core_result(core_result),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in cipher: known vectors, otherwise an invertible key mix.
  function automatic logic [127:0] cipher(input logic [255:0] k, input logic kl,
                                          input logic enc, input logic [127:0] b);
    logic [127:0] kf, t;
    if (!kl && k[255:128] == K128 && enc && b == PT) return CT128;
    if (kl && k == K256 && enc && b == PT) return CT256;
    if (kl && k == K256 && !enc && b == CT256) return PT;
    kf = k[255:128] ^ (kl ? k[127:0] : 128'h0);
    if (enc) begin
      t = b ^ kf;
      return {t[114:0], t[127:115]};
    end
    t = {b[12:0], b[127:13]};
    return t ^ kf;
  endfunction

  // ---------------- cipher core model ----------------
  logic         busy, busy_blk, blk_done;
  int           cnt;
  logic [127:0] issue_block;
  logic [255:0] issue_key;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready <= 1'b1; core_result_valid <= 1'b0; core_result <= '0;
      busy <= 1'b0; busy_blk <= 1'b0; blk_done <= 1'b0; cnt <= 0;
      issue_block <= '0; issue_key <= '0;
    end else begin
      blk_done <= 1'b0;
      if (core_init || core_next) begin
        core_ready <= 1'b0;
        busy       <= 1'b1;
        busy_blk   <= core_next;
        cnt        <= $urandom_range(2, 5);
        if (core_next) begin
          core_result_valid <= 1'b0;
          core_result <= cipher(core_key, core_keylen, core_encdec, core_block);
          issue_block <= core_block;
          issue_key   <= core_key;
        end
      end else if (busy) begin
        if (cnt == 1) begin
          busy <= 1'b0;
          core_ready <= 1'b1;
          if (busy_blk) begin
            core_result_valid <= 1'b1;
            blk_done <= 1'b1;
          end
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // ---------------- output ready driver ----------------
  logic rdy_mode = 1'b0;   // 0: random, 1: rdy_val
  logic rdy_val  = 1'b0;
  logic rnd_bit  = 1'b1;
  always @(posedge clk) begin
    #1 rnd_bit = ($urandom_range(0, 1) == 1);
  end
  assign sif.m_ready = rdy_mode ? rdy_val : rnd_bit;

  // ---------------- reference model + scoreboard ----------------
  logic [255:0] m_key;
  logic         m_kl, m_enc;
  logic [127:0] m_ctr;
  logic [31:0]  m_cnt;
  logic [159:0] exp_q[$];

  // Monitor: every output handshake pops one expected {blk_count, data}.
  always @(negedge clk) begin
    logic [159:0] e;
    if (reset_n && sif.m_valid && sif.m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 160'(sif.m_valid), 160'(1'b0));
      end else begin
        e = exp_q.pop_front();
        check("m_data", 160'(sif.m_data), 160'(e[127:0]));
        check("blk_count", 160'(blk_count), 160'(e[159:128]));
      end
    end
  end

  // Protocol checkers: strobe exclusivity, block operand stability, latency.
  logic lat_arm = 1'b0;
  always @(negedge clk) begin
    if (reset_n && (core_init || core_next))
      check("init_next_excl", 160'(core_init && core_next), 160'(1'b0));
    if (reset_n && busy && busy_blk) begin
      check("core_block_stable", 160'(core_block), 160'(issue_block));
      check("core_key_stable", 160'(core_key ^ issue_key), 160'(0));
    end
    if (reset_n && lat_arm) check("lat_m_valid", 160'(sif.m_valid), 160'(1'b1));
    lat_arm = reset_n && blk_done;
  end

  // ---------------- driver tasks ----------------
  task automatic load_key(input logic [255:0] k, input logic kl, input logic enc,
                          input logic [127:0] v);
    int b;
    @(posedge clk); #1;
    key_load = 1'b1; key = k; keylen = kl; encdec = enc; iv = v;
    @(posedge clk); #1;
    key_load = 1'b0;
    m_key = k; m_kl = kl; m_enc = enc; m_ctr = v; m_cnt = '0;
    b = 0;
    @(negedge clk);
    while (!core_init && b < 300) begin @(negedge clk); b++; end
    check("key_init_seen", 160'(core_init), 160'(1'b1));
    check("key_init_state", 160'(fsm_state), 160'(KEY_INIT));
    check("key_valid_low", 160'(key_valid), 160'(1'b0));
    @(negedge clk);
    check("init_one_cycle", 160'(core_init), 160'(1'b0));
    b = 0;
    while (!key_valid && b < 50) begin @(negedge clk); b++; end
    check("key_valid_high", 160'(key_valid), 160'(1'b1));
    check("s_ready_after_key", 160'(sif.s_ready), 160'(1'b1));
    check("blk_count_zero", 160'(blk_count), 160'(0));
  endtask

  task automatic send_block(input logic [127:0] d);
    int b;
    logic [127:0] e;
    @(posedge clk); #1;
    sif.s_valid = 1'b1; sif.s_data = d;
    b = 0;
    @(negedge clk);
    while (!sif.s_ready && b < 500) begin @(negedge clk); b++; end
    if (!sif.s_ready) begin
      check("send_timeout", 160'(0), 160'(1));
      sif.s_valid = 1'b0;
      return;
    end
`ifdef AES_STREAM_CTR_EN
    e = cipher(m_key, m_kl, 1'b1, m_ctr) ^ d;
    m_ctr[31:0] = m_ctr[31:0] + 32'd1;
`else
    e = cipher(m_key, m_kl, m_enc, d);
`endif
    m_cnt = m_cnt + 32'd1;
    exp_q.push_back({m_cnt, e});
    @(posedge clk); #1;
    sif.s_valid = 1'b0;
    @(negedge clk);
    check("lat_core_next", 160'(core_next), 160'(1'b1));
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || sif.m_valid) && b < 500) begin @(negedge clk); b++; end
    check("drain", 160'(exp_q.size()), 160'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] hold, v;
    logic [255:0] rk;
    int b;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_key_valid", 160'(key_valid), 160'(1'b0));
    check("rst_s_ready", 160'(sif.s_ready), 160'(1'b0));
    check("rst_m_valid", 160'(sif.m_valid), 160'(1'b0));
    check("rst_m_data", 160'(sif.m_data), 160'(0));
    check("rst_blk_count", 160'(blk_count), 160'(0));
    check("rst_strobes", 160'({core_init, core_next}), 160'(0));
    check("rst_state", 160'(fsm_state), 160'(IDLE));
    @(posedge clk); #3 reset_n = 1'b1;

    // AES-128 encrypt vector
    load_key({K128, 128'h0}, 1'b0, 1'b1, '0);
    send_block(PT);
    wait_drain();

    // AES-256 encrypt then decrypt
    load_key(K256, 1'b1, 1'b1, '0);
    send_block(PT);
    wait_drain();
    load_key(K256, 1'b1, 1'b0, '0);
    send_block(CT256);
    wait_drain();

    // Backpressure: hold m_ready low 10 cycles after m_valid
    rdy_mode = 1'b1; rdy_val = 1'b0;
    send_block({$urandom(), $urandom(), $urandom(), $urandom()});
    b = 0;
    while (!sif.m_valid && b < 50) begin @(negedge clk); b++; end
    check("bp_m_valid_rise", 160'(sif.m_valid), 160'(1'b1));
    hold = sif.m_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_m_data", 160'(sif.m_data), 160'(hold));
      check("bp_m_valid", 160'(sif.m_valid), 160'(1'b1));
      check("bp_s_ready", 160'(sif.s_ready), 160'(1'b0));
    end
    @(posedge clk); #2 rdy_val = 1'b1;
    @(posedge clk); #2 rdy_val = 1'b0;
    @(negedge clk);
    check("bp_s_ready_after", 160'(sif.s_ready), 160'(1'b1));
    check("bp_m_valid_after", 160'(sif.m_valid), 160'(1'b0));
    rdy_mode = 1'b0;

    // Randomized blocks with periodic random key reloads
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) begin
        rk = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        load_key(rk, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 {$urandom(), $urandom(), $urandom(), $urandom()});
      end
      send_block({$urandom(), $urandom(), $urandom(), $urandom()});
    end
    wait_drain();

    // key_load while a block is in BLK_WAIT: block keeps the old key
    send_block({$urandom(), $urandom(), $urandom(), $urandom()});
    @(negedge clk);
    check("kl_blk_wait_state", 160'(fsm_state), 160'(BLK_WAIT));
    rk = {$urandom(), $urandom(), $urandom(), $urandom(),
          $urandom(), $urandom(), $urandom(), $urandom()};
    load_key(rk, 1'b1, 1'b1, '0);
    wait_drain();
    send_block({$urandom(), $urandom(), $urandom(), $urandom()});
    wait_drain();

`ifdef AES_STREAM_CTR_EN
    // Counter wrap on the low word; upper 96 bits unchanged
    v = {$urandom(), $urandom(), $urandom(), 32'hffffffff};
    load_key({K128, 128'h0}, 1'b0, 1'b0, v);
    send_block(PT);
    check("ctr_first_block", 160'(core_block), 160'(v));
    send_block({$urandom(), $urandom(), $urandom(), $urandom()});
    check("ctr_wrap_block", 160'(core_block), 160'({v[127:32], 32'h0}));
    wait_drain();
`else
    v = '0;
`endif

    // Reset while a block is in BLK_WAIT: no output for it, ever
    send_block({$urandom(), $urandom(), $urandom(), $urandom()});
    @(posedge clk); #3 reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_state", 160'(fsm_state), 160'(IDLE));
    check("mid_rst_m_data", 160'(sif.m_data), 160'(0));
    check("mid_rst_blk_count", 160'(blk_count), 160'(0));
    repeat (2) @(negedge clk);
    @(posedge clk); #3 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abandon_m_valid", 160'(sif.m_valid), 160'(1'b0));
      check("abandon_key_valid", 160'(key_valid), 160'(1'b0));
      check("abandon_s_ready", 160'(sif.s_ready), 160'(1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
